axi64_bram_slave: RTL and testbench
===================================

// Module: axi64_bram_slave
// PURPOSE
//  AXI4 64-bit slave (responder) backed by a dual-port block RAM. It is the far end of the
//  axi64_interface master port driven by the VFU: it services INCR/FIXED bursts on separate
//  read and write channel FSMs and echoes transaction IDs. Used as on-chip vector scratch memory
//  in the Nexys example and as the memory model in VFU testbenches.
// PARAMETERS
//  DEPTH      1024         number of 64-bit words; power of 2
//  BASE_ADDR  32'h0000_0000 byte address of word 0; aligned to DEPTH*8
//  INIT_FILE  ""           $readmemh image; empty string = no init
// PORTS
//  clk  in  1  clock
//  rst  in  1  synchronous active-high reset
//  AR ch (in unless noted): s_axi_arvalid 1, s_axi_arready out 1, s_axi_araddr 32, s_axi_arlen 8,
//     s_axi_arsize 3, s_axi_arburst 2, s_axi_arcache 4, s_axi_arid 6
//  R ch (out unless noted): s_axi_rvalid 1, s_axi_rready in 1, s_axi_rdata 64, s_axi_rresp 2,
//     s_axi_rlast 1, s_axi_rid 6
//  AW ch (in unless noted): s_axi_awvalid 1, s_axi_awready out 1, s_axi_awaddr 32, s_axi_awlen 8,
//     s_axi_awsize 3, s_axi_awburst 2, s_axi_awcache 4, s_axi_awid 6
//  W ch (in unless noted): s_axi_wvalid 1, s_axi_wready out 1, s_axi_wdata 64, s_axi_wstrb 8, s_axi_wlast 1
//  B ch (out unless noted): s_axi_bvalid 1, s_axi_bready in 1, s_axi_bresp 2, s_axi_bid 6
// BEHAVIOUR
//  - Reset: all valid/ready outputs 0; rdata, rresp, rlast, rid, bresp, bid = 0; both FSMs idle.
//    Reset mid-burst abandons the burst without a response. RAM contents are retained.
//  - Word index = (addr - BASE_ADDR)[log2(DEPTH)+2:3]. addr[2:0], arsize/awsize and cache are
//    ignored; every beat is 64 bits.
//  - Burst: FIXED (2'b00) keeps the index. INCR (2'b01) and WRAP (2'b10, treated as INCR) add 1
//    per beat. The index wraps modulo DEPTH.
//  - Read FSM: R_IDLE -> R_ADDR -> R_DATA.
//    - R_IDLE: arready=1. On AR handshake, latch index, len, burst and id; go to R_ADDR.
//    - R_ADDR: issue the RAM read (1-cycle sync RAM); go to R_DATA.
//    - R_DATA: rvalid=1; rlast=(beat==len); rid=latched id; rresp=OKAY.
//    - rdata/rlast/rid are held stable while rvalid && !rready.
//    - On R handshake: if last, go to R_IDLE, else advance the index and go to R_ADDR.
//    - AR handshake at cycle N gives first rvalid at N+2; throughput is 1 beat per 2 cycles.
//  - Write FSM: W_IDLE -> W_DATA -> W_RESP.
//    - W_IDLE: awready=1. On AW handshake, latch index, len, burst and id; go to W_DATA.
//    - W_DATA: wready=1. Each W handshake writes the bytes whose wstrb bits are set; 1 beat/cycle.
//    - The burst ends after len+1 beats, counted internally; wlast does not end it.
//      If wlast disagrees with the beat count on any beat, a sticky flag sets bresp=SLVERR (2'b10).
//    - After the final beat, go to W_RESP.
//    - W_RESP: bvalid=1, bid=latched id, held until bready; then go to W_IDLE.
//    - AW handshake at N gives wready at N+1; bvalid follows the cycle after the last W handshake.
//  - Read and write run independently and concurrently.
//    - Same-word read and write in the same cycle: the read returns the old data (read-first).
//  - A W beat presented before AW is accepted is not consumed (wready=0 in W_IDLE).
//  - arlen=0 / awlen=0: single-beat bursts; rlast=1 on the only beat.
// CONFIGURATION
//  AXI64_SLAVE_RANGE_CHECK_EN:
//  - Defined: a beat whose address is outside [BASE_ADDR, BASE_ADDR+DEPTH*8) is checked per beat
//    after increment, so a burst crossing the top boundary errors mid-burst.
//    - Out-of-range read beat: rdata=0, rresp=DECERR (2'b11).
//    - Out-of-range write beat: the RAM write is suppressed and bresp=DECERR (DECERR has priority
//      over SLVERR). Burst length and handshakes are unchanged.
//  - Undefined: no check; the index wraps modulo DEPTH; resp is always OKAY (except the wlast SLVERR).
// TESTING
//  1. AW addr=0x40 len=3 id=5, data 0x11..,0x22..,0x33..,0x44.. with wstrb=FF
//     -> bvalid with bid=5, bresp=00; then AR 0x40 len=3 id=9 -> same 4 words, rid=9, rlast on beat 4 only.
//  2. Write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then 0x0 with wstrb=8'h0F; read back -> 0xFFFF_FFFF_0000_0000.
//  3. FIXED read len=2 at 0x8 -> 3 beats of the same word.
//     rready held low 5 cycles on beat 1 -> rdata/rlast stable throughout.
//  4. Write awlen=1 with wlast=1 on beat 1 -> bresp=2'b10; both beats written.
//  5. rst pulsed mid read burst (beat 2 of 4)
//     -> rvalid=0 next cycle, arready=1; a new AR is accepted normally and RAM data is intact.
//  6. With AXI64_SLAVE_RANGE_CHECK_EN, DEPTH=16: AR 0x78 len=1 -> beat 0 OKAY, beat 1 DECERR with rdata=0.
//     Without the macro: beat 1 returns word 0.

Source files
------------

// File: rtl/axi64_bram_slave.sv
// AXI4 64-bit responder over a byte-writable block RAM; read and write channels are independent FSMs.
// Optional feature macro: AXI64_SLAVE_RANGE_CHECK_EN (out-of-window beats answered with DECERR).
module axi64_bram_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic [3:0]  s_axi_arcache,
  input  logic [5:0]  s_axi_arid,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic [5:0]  s_axi_rid,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic [3:0]  s_axi_awcache,
  input  logic [5:0]  s_axi_awid,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  output logic [5:0]  s_axi_bid
);

  localparam int AW = $clog2(DEPTH);
`ifdef AXI64_SLAVE_RANGE_CHECK_EN
  // Keep the full word offset so a burst running past the top of the window is detectable.
  localparam int OFFW = 29;
`else
  localparam int OFFW = AW;
`endif
  localparam logic [28:0] BASE_W      = BASE_ADDR[31:3];
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  // The RAM image named by INIT_FILE is loaded by the device programming flow, not by this RTL.
  localparam bit unused_init_file = (INIT_FILE != "");

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [63:0] mem [DEPTH];

  logic [28:0] ar_woff;
  logic [28:0] aw_woff;
  assign ar_woff = s_axi_araddr[31:3] - BASE_W;
  assign aw_woff = s_axi_awaddr[31:3] - BASE_W;

  // Read channel state
  r_state_t        r_state_reg;
  logic [OFFW-1:0] r_off_reg;
  logic [7:0]      r_len_reg;
  logic [7:0]      r_beat_reg;
  logic            r_fixed_reg;
  logic            arready_reg;
  logic            rvalid_reg;
  logic [63:0]     rdata_reg;
  logic [1:0]      rresp_reg;
  logic            rlast_reg;
  logic [5:0]      rid_reg;

  // Write channel state
  w_state_t        w_state_reg;
  logic [OFFW-1:0] w_off_reg;
  logic [7:0]      w_len_reg;
  logic [7:0]      w_beat_reg;
  logic            w_fixed_reg;
  logic [5:0]      w_id_reg;
  logic            w_slverr_reg;
  logic            w_decerr_reg;
  logic            awready_reg;
  logic            wready_reg;
  logic            bvalid_reg;
  logic [1:0]      bresp_reg;
  logic [5:0]      bid_reg;

  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic          r_in_range;
  logic          w_in_range;
  logic          w_fire;
  logic          w_final;
  logic          w_mismatch;
  logic [7:0]    lane_we;
  logic          unused_bits;

  assign r_idx = r_off_reg[AW-1:0];
  assign w_idx = w_off_reg[AW-1:0];

`ifdef AXI64_SLAVE_RANGE_CHECK_EN
  assign r_in_range  = (r_off_reg[OFFW-1:AW] == '0);
  assign w_in_range  = (w_off_reg[OFFW-1:AW] == '0);
  assign unused_bits = ^{s_axi_araddr[2:0], s_axi_awaddr[2:0], s_axi_arsize, s_axi_awsize,
                         s_axi_arcache, s_axi_awcache};
`else
  assign r_in_range  = 1'b1;
  assign w_in_range  = 1'b1;
  assign unused_bits = ^{s_axi_araddr[2:0], s_axi_awaddr[2:0], s_axi_arsize, s_axi_awsize,
                         s_axi_arcache, s_axi_awcache, ar_woff[28:AW], aw_woff[28:AW]};
`endif

  assign w_fire     = (w_state_reg == W_DATA) && wready_reg && s_axi_wvalid;
  assign w_final    = (w_beat_reg == w_len_reg);
  assign w_mismatch = (s_axi_wlast != w_final);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_we[gi] = w_fire && w_in_range && s_axi_wstrb[gi] && !rst;
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (lane_we[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  // Read FSM; rdata_reg is the RAM output register, loaded only in R_ADDR so it holds during stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_off_reg   <= '0;
      r_len_reg   <= '0;
      r_beat_reg  <= '0;
      r_fixed_reg <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
      rlast_reg   <= 1'b0;
      rid_reg     <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (arready_reg && s_axi_arvalid) begin
            arready_reg <= 1'b0;
            r_off_reg   <= ar_woff[OFFW-1:0];
            r_len_reg   <= s_axi_arlen;
            r_beat_reg  <= '0;
            r_fixed_reg <= (s_axi_arburst == 2'b00);
            rid_reg     <= s_axi_arid;
            r_state_reg <= R_ADDR;
          end
        end
        R_ADDR: begin
          rvalid_reg <= 1'b1;
          rlast_reg  <= (r_beat_reg == r_len_reg);
          if (r_in_range) begin
            rdata_reg <= mem[r_idx];
            rresp_reg <= RESP_OKAY;
          end else begin
            rdata_reg <= '0;
            rresp_reg <= RESP_DECERR;
          end
          r_state_reg <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_reg <= 1'b0;
            if (rlast_reg) begin
              rlast_reg   <= 1'b0;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              r_beat_reg  <= r_beat_reg + 8'd1;
              if (!r_fixed_reg) r_off_reg <= r_off_reg + 1'b1;
              r_state_reg <= R_ADDR;
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // Write FSM; the beat count, not wlast, ends the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg  <= W_IDLE;
      w_off_reg    <= '0;
      w_len_reg    <= '0;
      w_beat_reg   <= '0;
      w_fixed_reg  <= 1'b0;
      w_id_reg     <= '0;
      w_slverr_reg <= 1'b0;
      w_decerr_reg <= 1'b0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      bid_reg      <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          if (awready_reg && s_axi_awvalid) begin
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b1;
            w_off_reg    <= aw_woff[OFFW-1:0];
            w_len_reg    <= s_axi_awlen;
            w_beat_reg   <= '0;
            w_fixed_reg  <= (s_axi_awburst == 2'b00);
            w_id_reg     <= s_axi_awid;
            w_slverr_reg <= 1'b0;
            w_decerr_reg <= 1'b0;
            w_state_reg  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_beat_reg <= w_beat_reg + 8'd1;
            if (!w_fixed_reg) w_off_reg <= w_off_reg + 1'b1;
            if (w_mismatch) w_slverr_reg <= 1'b1;
            if (!w_in_range) w_decerr_reg <= 1'b1;
            if (w_final) begin
              wready_reg  <= 1'b0;
              bvalid_reg  <= 1'b1;
              bid_reg     <= w_id_reg;
              if (w_decerr_reg || !w_in_range) bresp_reg <= RESP_DECERR;
              else if (w_slverr_reg || w_mismatch) bresp_reg <= RESP_SLVERR;
              else bresp_reg <= RESP_OKAY;
              w_state_reg <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = rresp_reg;
  assign s_axi_rlast   = rlast_reg;
  assign s_axi_rid     = rid_reg;
  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = wready_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_bid     = bid_reg;

endmodule

// File: tb/tb_axi64_bram_slave.sv
// Scoreboard bench for axi64_bram_slave: stimulus queues expected R/B responses, a negedge
// monitor pops and compares them on every handshake.
module tb_axi64_bram_slave;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd3;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic [3:0]  s_axi_arcache = '0;
  logic [5:0]  s_axi_arid = '0;
  logic        s_axi_rvalid, s_axi_rready = 1'b1;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic [5:0]  s_axi_rid;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd3;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic [3:0]  s_axi_awcache = '0;
  logic [5:0]  s_axi_awid = '0;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_bvalid, s_axi_bready = 1'b1;
  logic [1:0]  s_axi_bresp;
  logic [5:0]  s_axi_bid;

  always #5 clk = ~clk;

  axi64_bram_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arcache(s_axi_arcache), .s_axi_arid(s_axi_arid),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awcache(s_axi_awcache), .s_axi_awid(s_axi_awid),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bid(s_axi_bid)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  id;
  } r_exp_t;
  typedef struct {
    logic [1:0] resp;
    logic [5:0] id;
  } b_exp_t;

  r_exp_t      exp_r[$];
  b_exp_t      exp_b[$];
  r_exp_t      r_cur;
  b_exp_t      b_cur;
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          r_hs_cnt  = 0;
  int          b_hs_cnt  = 0;
  logic [63:0] wbeat[4];
  logic [63:0] rbeat[4];
  logic [1:0]  rresp_exp[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string what);
    total_cnt++;
    $display("FAIL %s: got no event within the cycle budget, expected one", what);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return s_axi_arready;
      1:       return s_axi_awready;
      2:       return s_axi_wready;
      3:       return s_axi_rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Returns at the first negedge where the selected signal is high; waited = negedges skipped.
  task automatic wait_hi(input int w, input string what, output int waited);
    waited = 0;
    @(negedge clk);
    while (!sig(w)) begin
      if (waited >= 64) begin
        timeout_fail(what);
        return;
      end
      waited++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rcnt(input int target);
    int n = 0;
    while (r_hs_cnt < target) begin
      if (n >= 200) begin
        timeout_fail("r_beats");
        return;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_bcnt(input int target);
    int n = 0;
    while (b_hs_cnt < target) begin
      if (n >= 200) begin
        timeout_fail("b_resp");
        return;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                           input logic [7:0] strb, input logic [7:0] wlast_mask,
                           input logic [1:0] exp_resp, input bit chk_lat);
    int target;
    int waited;
    exp_b.push_back('{resp: exp_resp, id: id});
    target = b_hs_cnt + 1;
    @(posedge clk); #1;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = 2'b01; s_axi_awid = id;
    s_axi_awvalid = 1'b1;
    wait_hi(1, "awready", waited);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = wbeat[0]; s_axi_wstrb = strb; s_axi_wlast = wlast_mask[0];
    for (int i = 0; i <= int'(len); i++) begin
      wait_hi(2, "wready", waited);
      if (chk_lat && i == 0) chk("w_latency", 64'(waited), 64'd0);
      @(posedge clk); #1;
      if (i < int'(len)) begin
        s_axi_wdata = wbeat[i+1];
        s_axi_wlast = wlast_mask[i+1];
      end else begin
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
      end
    end
    wait_bcnt(target);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [5:0] id, input bit chk_lat, input bit wait_done);
    int target;
    int waited;
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{data: rbeat[i], resp: rresp_exp[i], last: (i == int'(len)), id: id});
    target = r_hs_cnt + int'(len) + 1;
    @(posedge clk); #1;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst; s_axi_arid = id;
    s_axi_arvalid = 1'b1;
    wait_hi(0, "arready", waited);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      chk("r_latency_n1", 64'(s_axi_rvalid), 64'd0);
      @(negedge clk);
      chk("r_latency_n2", 64'(s_axi_rvalid), 64'd1);
    end
    if (wait_done) wait_rcnt(target);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && s_axi_rvalid && s_axi_rready) begin
      $display("R  id=%0d data=%h resp=%b last=%b", s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast);
      if (exp_r.size() == 0) begin
        total_cnt++;
        $display("FAIL r_unexpected: got beat data=%h, expected no beat", s_axi_rdata);
      end else begin
        r_cur = exp_r.pop_front();
        chk("r_data", s_axi_rdata, r_cur.data);
        chk("r_resp", 64'(s_axi_rresp), 64'(r_cur.resp));
        chk("r_last", 64'(s_axi_rlast), 64'(r_cur.last));
        chk("r_id", 64'(s_axi_rid), 64'(r_cur.id));
      end
      r_hs_cnt++;
    end
    if (!rst && s_axi_bvalid && s_axi_bready) begin
      $display("B  id=%0d resp=%b", s_axi_bid, s_axi_bresp);
      if (exp_b.size() == 0) begin
        total_cnt++;
        $display("FAIL b_unexpected: got resp id=%0d, expected no response", s_axi_bid);
      end else begin
        b_cur = exp_b.pop_front();
        chk("b_resp", 64'(s_axi_bresp), 64'(b_cur.resp));
        chk("b_id", 64'(s_axi_bid), 64'(b_cur.id));
      end
      b_hs_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target;
    int waited;
    for (int i = 0; i < 4; i++) rresp_exp[i] = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("rst_rdata", s_axi_rdata, 64'd0);
    chk("rst_rinfo", 64'({s_axi_rresp, s_axi_rlast, s_axi_rid}), 64'd0);
    chk("rst_binfo", 64'({s_axi_bresp, s_axi_bid}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", 64'(s_axi_arready), 64'd1);
    chk("idle_awready", 64'(s_axi_awready), 64'd1);

    // 1: four-beat INCR write then read back
    wbeat[0] = 64'h1111_1111_1111_1111; wbeat[1] = 64'h2222_2222_2222_2222;
    wbeat[2] = 64'h3333_3333_3333_3333; wbeat[3] = 64'h4444_4444_4444_4444;
    axi_write(32'h40, 8'd3, 6'd5, 8'hFF, 8'b1000, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) rbeat[i] = wbeat[i];
    axi_read(32'h40, 8'd3, 2'b01, 6'd9, 1'b1, 1'b1);

    // WRAP is treated as INCR
    rbeat[0] = 64'h2222_2222_2222_2222; rbeat[1] = 64'h3333_3333_3333_3333;
    axi_read(32'h48, 8'd1, 2'b10, 6'd10, 1'b0, 1'b1);

    // 2: byte strobes
    wbeat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(32'h0, 8'd0, 6'd1, 8'hFF, 8'b1, 2'b00, 1'b0);
    wbeat[0] = 64'h0;
    axi_write(32'h0, 8'd0, 6'd2, 8'h0F, 8'b1, 2'b00, 1'b0);
    rbeat[0] = 64'hFFFF_FFFF_0000_0000;
    axi_read(32'h0, 8'd0, 2'b01, 6'd3, 1'b0, 1'b1);

    // 3: FIXED read with a 5-cycle stall on beat 1
    wbeat[0] = 64'hA5A5_5A5A_0123_4567;
    axi_write(32'h8, 8'd0, 6'd11, 8'hFF, 8'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) rbeat[i] = 64'hA5A5_5A5A_0123_4567;
    s_axi_rready = 1'b0;
    target = r_hs_cnt + 3;
    axi_read(32'h8, 8'd2, 2'b00, 6'd12, 1'b0, 1'b0);
    wait_hi(3, "rvalid_stall", waited);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_rvalid", 64'(s_axi_rvalid), 64'd1);
      chk("stall_rdata", s_axi_rdata, 64'hA5A5_5A5A_0123_4567);
      chk("stall_rlast", 64'(s_axi_rlast), 64'd0);
    end
    @(posedge clk); #1;
    s_axi_rready = 1'b1;
    wait_rcnt(target);

    // 4: early wlast gives SLVERR, both beats still written
    wbeat[0] = 64'hBEEF_0000_BEEF_0001; wbeat[1] = 64'hCAFE_0000_CAFE_0002;
    axi_write(32'h20, 8'd1, 6'd4, 8'hFF, 8'b01, 2'b10, 1'b0);
    rbeat[0] = wbeat[0]; rbeat[1] = wbeat[1];
    axi_read(32'h20, 8'd1, 2'b01, 6'd13, 1'b0, 1'b1);

    // 5: reset during beat 2 of a 4-beat read
    for (int i = 0; i < 4; i++) rbeat[i] = {16{i[1:0] + 2'd1}};
    rbeat[0] = 64'h1111_1111_1111_1111; rbeat[1] = 64'h2222_2222_2222_2222;
    rbeat[2] = 64'h3333_3333_3333_3333; rbeat[3] = 64'h4444_4444_4444_4444;
    target = r_hs_cnt + 1;
    axi_read(32'h40, 8'd3, 2'b01, 6'd7, 1'b0, 1'b0);
    wait_rcnt(target);
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    wait_hi(3, "rvalid_beat2", waited);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(s_axi_rvalid), 64'd0);
    exp_r.delete();
    @(negedge clk);
    chk("rst_mid_arready", 64'(s_axi_arready), 64'd1);
    s_axi_rready = 1'b1;
    axi_read(32'h40, 8'd3, 2'b01, 6'd3, 1'b0, 1'b1);

    // 6: burst crossing the top of the window
    wbeat[0] = 64'h7878_7878_7878_7878;
    axi_write(32'h78, 8'd0, 6'd6, 8'hFF, 8'b1, 2'b00, 1'b0);
    rbeat[0] = 64'h7878_7878_7878_7878;
`ifdef AXI64_SLAVE_RANGE_CHECK_EN
    rbeat[1] = 64'h0; rresp_exp[1] = 2'b11;
`else
    rbeat[1] = 64'hFFFF_FFFF_0000_0000; rresp_exp[1] = 2'b00;
`endif
    axi_read(32'h78, 8'd1, 2'b01, 6'd6, 1'b0, 1'b1);
    rresp_exp[1] = 2'b00;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("r_queue_drained", 64'(exp_r.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
